// File: rtl/sprite_line_scheduler.sv
// Double-buffered sprite table, scanned in hblank for the next scanline; the per-line
// sprite list (lowest indices first, up to MAX_PER_LINE) is registered at line start.
module sprite_line_scheduler #(
  parameter int NUM_SPRITES         = 16,
  parameter int MAX_PER_LINE        = 4,
  parameter int SPRITE_FRAME_HEIGHT = 128,
  parameter int NUM_FRAMES          = 5,
  parameter int H_ACTIVE            = 1280,
  parameter int H_TOTAL             = 1650,
  parameter int V_ACTIVE            = 720,
  parameter int V_TOTAL             = 750
) (
  input  logic                                                clk_pixel,
  input  logic                                                sys_rst,
  input  logic [10:0]                                         hcount,
  input  logic [9:0]                                          vcount,
  input  logic                                                new_frame,
  input  logic                                                wr_en,
  input  logic [$clog2(NUM_SPRITES)-1:0]                      wr_idx,
  input  logic                                                wr_valid,
  input  logic [10:0]                                         wr_x,
  input  logic [9:0]                                          wr_y,
  input  logic [$clog2(NUM_FRAMES)-1:0]                       wr_frame,
  input  logic                                                commit,
  output logic [MAX_PER_LINE-1:0]                             slot_valid,
  output logic [MAX_PER_LINE*11-1:0]                          slot_x,
  output logic [MAX_PER_LINE*$clog2(NUM_FRAMES)-1:0]          slot_frame,
  output logic [MAX_PER_LINE*$clog2(SPRITE_FRAME_HEIGHT)-1:0] slot_row,
  output logic                                                overflow,
  output logic                                                busy
);

  localparam int IW = $clog2(NUM_SPRITES);
  localparam int FW = $clog2(NUM_FRAMES);
  localparam int RW = $clog2(SPRITE_FRAME_HEIGHT);
  localparam int SW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;

  localparam logic [10:0]   H_SCAN    = 11'(H_ACTIVE);
  localparam logic [10:0]   H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    V_END     = 10'(V_ACTIVE);
  localparam logic [10:0]   SPR_H     = 11'(SPRITE_FRAME_HEIGHT);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_SPRITES - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(MAX_PER_LINE - 1);

  typedef struct packed {
    logic          valid;
    logic [10:0]   x;
    logic [9:0]    y;
    logic [FW-1:0] frame;
  } entry_t;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  entry_t shadow_tbl [NUM_SPRITES];
  entry_t active_tbl [NUM_SPRITES];
  logic   commit_pending;
  entry_t wr_entry;

  assign wr_entry = '{valid: wr_valid, x: wr_x, y: wr_y, frame: wr_frame};

  // Nonblocking copy means a write in the swap cycle reaches shadow only.
  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        shadow_tbl[i] <= '0;
        active_tbl[i] <= '0;
      end
      commit_pending <= 1'b0;
    end else begin
      if (wr_en) begin
        shadow_tbl[wr_idx] <= wr_entry;
      end
      if (new_frame && commit_pending) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          active_tbl[i] <= shadow_tbl[i];
        end
        commit_pending <= commit;
      end else if (commit) begin
        commit_pending <= 1'b1;
      end
    end
  end

  state_t          state;
  logic [IW-1:0]   scan_idx;
  logic [9:0]      line_q;
  logic [SW-1:0]   pend_slot;
  logic            pend_full;
  logic            pend_overflow;
  logic [MAX_PER_LINE-1:0] pend_valid;
  logic [10:0]     pend_x     [MAX_PER_LINE];
  logic [FW-1:0]   pend_frame [MAX_PER_LINE];
  logic [RW-1:0]   pend_row   [MAX_PER_LINE];

  logic [9:0]      next_line;
  entry_t          cur;
  logic [10:0]     line_w;
  logic [10:0]     top_w;
  logic            hit;
  logic [RW-1:0]   hit_row;

  assign next_line = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
  assign cur       = active_tbl[scan_idx];
  assign line_w    = {1'b0, line_q};
  assign top_w     = {1'b0, cur.y};
  // Range test is done at 11 bits so y near the bottom of the 10-bit space cannot wrap.
  assign hit       = cur.valid && (line_q < V_END) &&
                     (line_w >= top_w) && (line_w < top_w + SPR_H);
  assign hit_row   = line_q[RW-1:0] - cur.y[RW-1:0];

  always_ff @(posedge clk_pixel) begin
    if (sys_rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      scan_idx      <= '0;
      line_q        <= '0;
      pend_slot     <= '0;
      pend_full     <= 1'b0;
      pend_overflow <= 1'b0;
      pend_valid    <= '0;
      for (int i = 0; i < MAX_PER_LINE; i++) begin
        pend_x[i]     <= '0;
        pend_frame[i] <= '0;
        pend_row[i]   <= '0;
      end
      slot_valid <= '0;
      slot_x     <= '0;
      slot_frame <= '0;
      slot_row   <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hcount == H_SCAN) begin
            state         <= SCAN;
            busy          <= 1'b1;
            scan_idx      <= '0;
            line_q        <= next_line;
            pend_slot     <= '0;
            pend_full     <= 1'b0;
            pend_overflow <= 1'b0;
            pend_valid    <= '0;
            for (int i = 0; i < MAX_PER_LINE; i++) begin
              pend_x[i]     <= '0;
              pend_frame[i] <= '0;
              pend_row[i]   <= '0;
            end
          end
        end
        SCAN: begin
          if (hit) begin
            if (pend_full) begin
              pend_overflow <= 1'b1;
            end else begin
              pend_valid[pend_slot] <= 1'b1;
              pend_x[pend_slot]     <= cur.x;
              pend_frame[pend_slot] <= cur.frame;
              pend_row[pend_slot]   <= hit_row;
              if (pend_slot == SLOT_LAST) begin
                pend_full <= 1'b1;
              end else begin
                pend_slot <= pend_slot + SW'(1);
              end
            end
          end
          if (scan_idx == IDX_LAST) begin
            state <= DONE;
            busy  <= 1'b0;
          end else begin
            scan_idx <= scan_idx + IW'(1);
          end
        end
        DONE: begin
          // Loading on the last hcount makes the list valid from hcount 0 of the target line.
          if (hcount == H_LAST) begin
            state      <= IDLE;
            slot_valid <= pend_valid;
            overflow   <= pend_overflow;
            for (int i = 0; i < MAX_PER_LINE; i++) begin
              slot_x[i*11 +: 11]     <= pend_x[i];
              slot_frame[i*FW +: FW] <= pend_frame[i];
              slot_row[i*RW +: RW]   <= pend_row[i];
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Scoreboard bench: a table model predicts each line's sprite list when its hblank scan
// starts; the prediction is compared with the DUT outputs at the start of that line.
module tb_sprite_line_scheduler;
  localparam int NS  = 16;
  localparam int MPL = 4;
  localparam int SH  = 8;
  localparam int NF  = 5;
  localparam int HA  = 40;
  localparam int HT  = 64;
  localparam int VA  = 24;
  localparam int VT  = 28;
  localparam int FRAME_CYC = HT * VT;

  logic        clk_pixel;
  logic        sys_rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        new_frame;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic        wr_valid;
  logic [10:0] wr_x;
  logic [9:0]  wr_y;
  logic [2:0]  wr_frame;
  logic        commit;
  logic [3:0]  slot_valid;
  logic [43:0] slot_x;
  logic [11:0] slot_frame;
  logic [11:0] slot_row;
  logic        overflow;
  logic        busy;

  sprite_line_scheduler #(
    .NUM_SPRITES(NS), .MAX_PER_LINE(MPL), .SPRITE_FRAME_HEIGHT(SH), .NUM_FRAMES(NF),
    .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .clk_pixel(clk_pixel), .sys_rst(sys_rst), .hcount(hcount), .vcount(vcount),
    .new_frame(new_frame), .wr_en(wr_en), .wr_idx(wr_idx), .wr_valid(wr_valid),
    .wr_x(wr_x), .wr_y(wr_y), .wr_frame(wr_frame), .commit(commit),
    .slot_valid(slot_valid), .slot_x(slot_x), .slot_frame(slot_frame),
    .slot_row(slot_row), .overflow(overflow), .busy(busy)
  );

  typedef struct packed {
    logic [3:0]  vld;
    logic [43:0] x;
    logic [11:0] fr;
    logic [11:0] row;
    logic        ovf;
  } exp_t;

  typedef struct {
    bit valid;
    int x;
    int y;
    int fr;
  } spr_t;

  spr_t m_shadow [NS];
  spr_t m_active [NS];
  bit   m_pend;
  bit   scan_live;
  exp_t exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t expect_line(input int L);
    exp_t e;
    int   n;
    e = '0;
    n = 0;
    if (L < VA) begin
      for (int i = 0; i < NS; i++) begin
        if (m_active[i].valid && L >= m_active[i].y && L < m_active[i].y + SH) begin
          if (n < MPL) begin
            e.vld[n]        = 1'b1;
            e.x[n*11 +: 11] = 11'(m_active[i].x);
            e.fr[n*3 +: 3]  = 3'(m_active[i].fr);
            e.row[n*3 +: 3] = 3'(L - m_active[i].y);
            n++;
          end else begin
            e.ovf = 1'b1;
          end
        end
      end
    end
    return e;
  endfunction

  initial begin
    clk_pixel = 1'b0;
    forever #5 clk_pixel = ~clk_pixel;
  end

  // Video timing: advances just after each rising edge.
  initial begin
    hcount = '0;
    vcount = '0;
    new_frame = 1'b1;
    forever begin
      @(posedge clk_pixel);
      #1;
      if (int'(hcount) == HT - 1) begin
        hcount = '0;
        vcount = (int'(vcount) == VT - 1) ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount = hcount + 11'd1;
      end
      new_frame = (hcount == 11'd0) && (vcount == 10'd0);
    end
  end

  // Reference model, sampling the same inputs the DUT sees at each edge.
  always @(posedge clk_pixel) begin
    if (sys_rst) begin
      for (int i = 0; i < NS; i++) begin
        m_shadow[i] = '{0, 0, 0, 0};
        m_active[i] = '{0, 0, 0, 0};
      end
      m_pend = 0;
      scan_live = 0;
      exp_q.delete();
    end else begin
      if (int'(hcount) == HA) begin
        exp_q.push_back(expect_line((int'(vcount) == VT - 1) ? 0 : int'(vcount) + 1));
        scan_live = 1;
      end
      if (new_frame && m_pend) begin
        m_active = m_shadow;
        m_pend = commit;
      end else if (commit) begin
        m_pend = 1;
      end
      if (wr_en) begin
        m_shadow[wr_idx] = '{wr_valid, int'(wr_x), int'(wr_y), int'(wr_frame)};
      end
    end
  end

  always @(negedge clk_pixel) begin
    exp_t e;
    if (hcount == 11'd0) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check_eq($sformatf("slot_valid line%0d", vcount), 64'(slot_valid), 64'(e.vld));
      check_eq($sformatf("slot_x line%0d", vcount), 64'(slot_x), 64'(e.x));
      check_eq($sformatf("slot_frame line%0d", vcount), 64'(slot_frame), 64'(e.fr));
      check_eq($sformatf("slot_row line%0d", vcount), 64'(slot_row), 64'(e.row));
      check_eq($sformatf("overflow line%0d", vcount), 64'(overflow), 64'(e.ovf));
    end
    if (int'(hcount) == HA + 1)
      check_eq($sformatf("busy_scan line%0d", vcount), 64'(busy), 64'(scan_live));
    if (int'(hcount) == HA + NS + 1)
      check_eq($sformatf("busy_done line%0d", vcount), 64'(busy), 64'd0);
  end

  task automatic wait_at(input int h, input int v);
    int n;
    n = 0;
    do begin
      @(negedge clk_pixel);
      n++;
    end while (!(int'(hcount) == h && int'(vcount) == v) && n < 2 * FRAME_CYC);
    if (n >= 2 * FRAME_CYC) check_eq("wait_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_frames(input int n);
    repeat (n) wait_at(0, 0);
  endtask

  task automatic wr_sprite(input int idx, input bit v, input int x, input int y, input int fr);
    @(negedge clk_pixel);
    wr_en = 1'b1;
    wr_idx = 4'(idx);
    wr_valid = v;
    wr_x = 11'(x);
    wr_y = 10'(y);
    wr_frame = 3'(fr);
    @(negedge clk_pixel);
    wr_en = 1'b0;
  endtask

  task automatic pulse_commit();
    @(negedge clk_pixel);
    commit = 1'b1;
    @(negedge clk_pixel);
    commit = 1'b0;
  endtask

  initial begin
    sys_rst = 1'b1;
    wr_en = 1'b0;
    wr_idx = '0;
    wr_valid = 1'b0;
    wr_x = '0;
    wr_y = '0;
    wr_frame = '0;
    commit = 1'b0;
    repeat (5) @(negedge clk_pixel);
    sys_rst = 1'b0;

    // Empty table: two blank frames.
    wait_frames(2);

    // Single sprite covering lines 10..17.
    wr_sprite(3, 1, 100, 10, 1);
    pulse_commit();
    wait_frames(2);

    // Six sprites on one band (overflow), plus wrap-line, blank-region and off-screen entries.
    for (int i = 0; i < 6; i++) wr_sprite(i, 1, 10 * i + 5, 4, i % NF);
    wr_sprite(7, 1, 600, 20, 3);
    wr_sprite(8, 1, 700, 0, 2);
    wr_sprite(9, 1, 800, 25, 4);
    pulse_commit();
    wait_frames(2);

    // Shadow write without commit stays invisible, then commit.
    wr_sprite(10, 1, 200, 12, 4);
    wr_sprite(3, 0, 0, 0, 0);
    wait_frames(3);
    pulse_commit();
    wait_frames(2);

    // Write landing in the swap cycle goes to shadow only.
    wait_at(20, 5);
    wr_sprite(11, 1, 300, 14, 1);
    pulse_commit();
    wait_at(0, 0);
    wr_en = 1'b1;
    wr_idx = 4'd11;
    wr_valid = 1'b1;
    wr_x = 11'd50;
    wr_y = 10'd2;
    wr_frame = 3'd3;
    @(negedge clk_pixel);
    wr_en = 1'b0;
    wait_frames(2);
    pulse_commit();
    wait_frames(2);

    // Reset in the middle of a scan.
    wait_at(HA + 5, 11);
    check_eq("busy_mid_scan", 64'(busy), 64'd1);
    sys_rst = 1'b1;
    @(negedge clk_pixel);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_slot_valid", 64'(slot_valid), 64'd0);
    check_eq("rst_overflow", 64'(overflow), 64'd0);
    check_eq("rst_slot_x", 64'(slot_x), 64'd0);
    sys_rst = 1'b0;
    wait_frames(1);
    wr_sprite(5, 1, 77, 6, 2);
    pulse_commit();
    wait_frames(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(40 * FRAME_CYC * 10);
    $display("FAIL watchdog checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
